fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the RISC-V cores. It replaces the bare program_counter plus pc+4 adder path with a sequential fetcher that has:
- a valid/ready request interface to instruction memory tolerating arbitrary response latency;
- an in-order buffer of in-flight and returned instructions;
- redirect (branch/jump) handling with squash of stale responses;
- misaligned-target detection.
It sits between instruction memory and decode, and serves both the multicycle and the pipelined datapaths.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 109 ++++++++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage: fetch FSM state
// encodings, instruction width, PC increment, and a PC alignment helper.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_STEP    = 4;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_t;

  // Instructions are 32-bit words, so a legal fetch target has its two
  // low address bits clear.
  function automatic logic pc_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// In-order buffer of fetch entries {pc, inst, filled}. Entries are allocated
// when a request is issued, filled when the matching response returns, and
// dequeued from the head by decode. Pointers carry one extra wrap bit so a
// full buffer is distinguishable from an empty one.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   alloc_en        allocate the entry at the alloc pointer (request issued)
//   alloc_pc        PC stored in the allocated entry
//   fill_en         fill the entry at the fill pointer (response accepted)
//   fill_inst       instruction stored in the filled entry
//   deq_en          drop the head entry (decode consumed it)
//   flush           make all pointers equal (everything in the buffer is stale)
//   occupancy       entries allocated and not yet dequeued
//   inflight        entries allocated and not yet filled
//   head_valid      head entry exists and has its instruction
//   head_inst       instruction of the head entry
//   head_pc         PC of the head entry
// ---------------------------------------------------------------------------
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BUF_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_en,
  input  logic [XLEN-1:0]              alloc_pc,
  input  logic                         fill_en,
  input  logic [INST_WIDTH-1:0]        fill_inst,
  input  logic                         deq_en,
  input  logic                         flush,
  output logic [$clog2(BUF_DEPTH):0]   occupancy,
  output logic [$clog2(BUF_DEPTH):0]   inflight,
  output logic                         head_valid,
  output logic [INST_WIDTH-1:0]        head_inst,
  output logic [XLEN-1:0]              head_pc
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]      alloc_ptr;
  logic [PTR_W-1:0]      fill_ptr;
  logic [PTR_W-1:0]      head_ptr;
  logic [IDX_W-1:0]      alloc_idx;
  logic [IDX_W-1:0]      fill_idx;
  logic [IDX_W-1:0]      head_idx;
  logic [BUF_DEPTH-1:0]  filled;
  logic [XLEN-1:0]       pc_mem   [BUF_DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [BUF_DEPTH];

  assign alloc_idx = alloc_ptr[IDX_W-1:0];
  assign fill_idx  = fill_ptr[IDX_W-1:0];
  assign head_idx  = head_ptr[IDX_W-1:0];

  assign occupancy = alloc_ptr - head_ptr;
  assign inflight  = alloc_ptr - fill_ptr;

  // A slot's filled bit is cleared when the slot is allocated, so a stale
  // bit from a previous lap can never make a fresh head look ready.
  assign head_valid = (occupancy != '0) && filled[head_idx];
  assign head_inst  = inst_mem[head_idx];
  assign head_pc    = pc_mem[head_idx];

  // Pointer and filled-flag state. The caller guarantees alloc and fill
  // never target the same slot in one cycle (that would need the buffer
  // to be both empty-in-flight and full at once).
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      filled    <= '0;
    end else if (flush) begin
      fill_ptr  <= alloc_ptr;
      head_ptr  <= alloc_ptr;
      filled    <= '0;
    end else begin
      if (alloc_en) begin
        alloc_ptr         <= alloc_ptr + PTR_ONE;
        filled[alloc_idx] <= 1'b0;
      end
      if (fill_en) begin
        fill_ptr         <= fill_ptr + PTR_ONE;
        filled[fill_idx] <= 1'b1;
      end
      if (deq_en) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
    end
  end

  // Entry payload storage needs no reset; validity is tracked by the
  // pointers and filled flags above.
  always_ff @(posedge clk) begin
    if (alloc_en && !flush) begin
      pc_mem[alloc_idx] <= alloc_pc;
    end
    if (fill_en && !flush) begin
      inst_mem[fill_idx] <= fill_inst;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetcher between instruction memory and decode.
// Issues PC-sequential requests over a valid/ready interface, keeps an
// in-order buffer of outstanding and returned instructions, handles
// redirects by flushing the buffer and discarding responses of the old
// stream, and parks in a fault state on a misaligned redirect target.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   fetch_en          permits new requests (0 stalls issue only)
//   redirect_en       one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc       new fetch target
//   imem_req_valid    request valid (combinational)
//   imem_req_ready    memory accepts the request
//   imem_req_addr     request address (current fetch PC)
//   imem_resp_valid   in-order response, latency >= 1, never back-pressured
//   imem_resp_data    returned instruction word
//   inst_valid        instruction at buffer head available to decode
//   inst_ready        decode consumes the head instruction
//   inst, inst_pc     head instruction and its PC
//   fault_valid       misaligned redirect target pending
//   fault_pc          the offending target
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_en,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [XLEN-1:0]       inst_pc,
  output logic                  fault_valid,
  output logic [XLEN-1:0]       fault_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_TOTAL = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [XLEN-1:0]  PC_INC      = XLEN'(PC_STEP);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  fetch_pc_next;
  logic [XLEN-1:0]  fault_pc_q;
  logic [XLEN-1:0]  fault_pc_next;
  logic [CNT_W-1:0] discard_cnt;
  logic [CNT_W-1:0] discard_next;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   pending_total;
  logic [CNT_W-1:0] resp_taken;
  logic             req_fire;
  logic             resp_drop;
  logic             resp_fill;
  logic             deq_fire;

  // Entries still in the buffer plus responses still owed to the old
  // stream; together they bound how many more requests may be in flight.
  assign pending_total = {1'b0, occupancy} + {1'b0, discard_cnt};

  assign imem_req_addr = fetch_pc;
  assign fault_pc      = fault_pc_q;

  fetch_buffer #(
    .XLEN      (XLEN),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (req_fire),
    .alloc_pc   (fetch_pc),
    .fill_en    (resp_fill),
    .fill_inst  (imem_resp_data),
    .deq_en     (deq_fire),
    .flush      (redirect_en),
    .occupancy  (occupancy),
    .inflight   (inflight),
    .head_valid (inst_valid),
    .head_inst  (inst),
    .head_pc    (inst_pc)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_RUN;
      fetch_pc    <= RESET_PC;
      fault_pc_q  <= '0;
      discard_cnt <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      fault_pc_q  <= fault_pc_next;
      discard_cnt <= discard_next;
    end
  end

  // Next-state, issue and response-steering logic. A redirect overrides
  // everything else in its cycle: no issue, no dequeue, and every response
  // still owed to the old stream (in flight now, minus one arriving this
  // cycle) is added to the discard count.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    fault_pc_next = fault_pc_q;
    discard_next  = discard_cnt;

    imem_req_valid = (state == FETCH_RUN) && fetch_en && !redirect_en &&
                     (pending_total < DEPTH_TOTAL);
    fault_valid    = (state == FETCH_FAULT);

    req_fire  = imem_req_valid && imem_req_ready;
    resp_drop = imem_resp_valid && (discard_cnt != '0);
    resp_fill = imem_resp_valid && (discard_cnt == '0) && (inflight != '0) &&
                !redirect_en;
    deq_fire  = inst_valid && inst_ready && !redirect_en;

    resp_taken = (imem_resp_valid && ((discard_cnt != '0) || (inflight != '0)))
                 ? CNT_ONE : '0;

    if (redirect_en) begin
      discard_next = discard_cnt + inflight - resp_taken;
      if (pc_aligned(redirect_pc[1:0])) begin
        state_next    = FETCH_RUN;
        fetch_pc_next = redirect_pc;
      end else begin
        state_next    = FETCH_FAULT;
        fault_pc_next = redirect_pc;
      end
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc + PC_INC;
      end
      if (resp_drop) begin
        discard_next = discard_cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Scoreboard bench for fetch_unit. Stimulus pushes the expected {pc, inst}
// pairs into a queue; a monitor pops and compares every instruction decode
// accepts. Direct checks cover issue timing, stalls, redirects and faults.
// A second 32-bit instance covers PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct packed {
    logic [63:0] addr;
    int          wait_cyc;
  } mreq_t;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fault_valid;
  logic [63:0] fault_pc;

  logic        w_fetch_en;
  logic        w_redirect_en;
  logic [31:0] w_redirect_pc;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_inst_valid;
  logic        w_inst_ready;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_fault_valid;
  logic [31:0] w_fault_pc;

  int    checks;
  int    failures;
  int    mem_lat;
  exp_t  exp_q[$];
  mreq_t pend[$];

  fetch_unit #(
    .XLEN      (64),
    .RESET_PC  (64'h0),
    .BUF_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fault_valid     (fault_valid),
    .fault_pc        (fault_pc)
  );

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (4)
  ) dut32 (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (w_fetch_en),
    .redirect_en     (w_redirect_en),
    .redirect_pc     (w_redirect_pc),
    .imem_req_valid  (w_req_valid),
    .imem_req_ready  (w_req_ready),
    .imem_req_addr   (w_req_addr),
    .imem_resp_valid (w_resp_valid),
    .imem_resp_data  (w_resp_data),
    .inst_valid      (w_inst_valid),
    .inst_ready      (w_inst_ready),
    .inst            (w_inst),
    .inst_pc         (w_inst_pc),
    .fault_valid     (w_fault_valid),
    .fault_pc        (w_fault_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h0013};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic rs, input logic fe, input logic rde,
                               input logic [63:0] rpc, input logic ird);
    @(posedge clk);
    #1;
    rst         = rs;
    fetch_en    = fe;
    redirect_en = rde;
    redirect_pc = rpc;
    inst_ready  = ird;
  endtask

  task automatic expectInst(input logic [63:0] pc);
    exp_q.push_back('{pc: pc, word: mem_word(pc)});
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  // Instruction memory model: in-order responses after mem_lat cycles.
  // Handshakes are sampled on the falling edge; responses are driven just
  // after the rising edge. Reset clears every outstanding request.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
      end else begin
        if (imem_resp_valid && pend.size() != 0) void'(pend.pop_front());
        if (imem_req_valid && imem_req_ready)
          pend.push_back('{addr: imem_req_addr, wait_cyc: mem_lat});
      end
      @(posedge clk);
      #1;
      foreach (pend[i]) pend[i].wait_cyc = pend[i].wait_cyc - 1;
      if (pend.size() != 0 && pend[0].wait_cyc <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  // Scoreboard monitor: every accepted instruction must match the oldest
  // expectation. A redirect cycle does not consume the head.
  always @(negedge clk) begin
    if (!rst && !redirect_en && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected: got pc 0x%0h, expected no instruction", inst_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_inst_pc", inst_pc, e.pc);
        checkOutput("sb_inst", 64'(inst), 64'(e.word));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    checks         = 0;
    failures       = 0;
    mem_lat        = 1;
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_en    = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    w_fetch_en     = 1'b0;
    w_redirect_en  = 1'b0;
    w_redirect_pc  = '0;
    w_req_ready    = 1'b1;
    w_resp_valid   = 1'b0;
    w_resp_data    = '0;
    w_inst_ready   = 1'b0;

    // Test 1: reset state, then streaming fetch with latency-1 memory.
    doReset();
    doReset();
    @(negedge clk);
    checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("rst_fault_valid", 64'(fault_valid), 64'd0);
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_req_addr", imem_req_addr, 64'h0);
    for (int i = 0; i < 6; i++) expectInst(64'(4 * i));
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("t1_req_valid", 64'(imem_req_valid), 64'd1);
      checkOutput("t1_req_addr", imem_req_addr, 64'(4 * i));
      if (i <= 2) checkOutput("t1_inst_valid_timing", 64'(inst_valid), (i == 2) ? 64'd1 : 64'd0);
      if (i < 5) applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    waitDrain("t1_drain");

    // Test 2: decode stalled, buffer fills after four requests.
    doReset();
    mem_lat = 1;
    for (int i = 0; i < 5; i++) expectInst(64'(4 * i));
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) n++;
      if (i == 5) begin
        checkOutput("t2_full_stall", 64'(imem_req_valid), 64'd0);
        checkOutput("t2_head_valid", 64'(inst_valid), 64'd1);
      end
      if (i < 5) applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    end
    checkOutput("t2_issue_count", 64'(n), 64'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    checkOutput("t2_still_full", 64'(imem_req_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    checkOutput("t2_resume_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("t2_resume_addr", imem_req_addr, 64'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    waitDrain("t2_drain");

    // Test 3: redirect with three requests in flight at latency 3.
    doReset();
    mem_lat = 3;
    expectInst(64'h100);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
      @(negedge clk);
      checkOutput("t3_pre_addr", imem_req_addr, 64'(4 * i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h100, 1'b1);
    @(negedge clk);
    checkOutput("t3_redirect_no_issue", 64'(imem_req_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    checkOutput("t3_new_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("t3_new_addr", imem_req_addr, 64'h100);
    checkOutput("t3_stale_hidden", 64'(inst_valid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      @(negedge clk);
      checkOutput("t3_stale_hidden", 64'(inst_valid), 64'd0);
    end
    waitDrain("t3_drain");

    // Test 4: misaligned redirect faults, aligned redirect recovers.
    doReset();
    mem_lat = 1;
    expectInst(64'h200);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h102, 1'b0);
    @(negedge clk);
    checkOutput("t4_fault_not_yet", 64'(fault_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    checkOutput("t4_fault_valid", 64'(fault_valid), 64'd1);
    checkOutput("t4_fault_pc", fault_pc, 64'h102);
    checkOutput("t4_fault_no_issue", 64'(imem_req_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h200, 1'b1);
    @(negedge clk);
    checkOutput("t4_fault_hold", 64'(fault_valid), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    checkOutput("t4_fault_cleared", 64'(fault_valid), 64'd0);
    checkOutput("t4_resume_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("t4_resume_addr", imem_req_addr, 64'h200);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    waitDrain("t4_drain");

    // Test 6: reset with entries buffered and requests in flight.
    doReset();
    mem_lat = 3;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    checkOutput("t6_buffered", 64'(inst_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    mem_lat = 1;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    checkOutput("t6_inst_valid", 64'(inst_valid), 64'd0);
    checkOutput("t6_fault_valid", 64'(fault_valid), 64'd0);
    checkOutput("t6_req_addr", imem_req_addr, 64'h0);
    expectInst(64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    waitDrain("t6_drain");

    // Test 5: 32-bit instance wraps the fetch PC past the top of memory.
    @(posedge clk);
    #1;
    w_fetch_en    = 1'b1;
    w_redirect_en = 1'b1;
    w_redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    checkOutput("t5_redirect_no_issue", 64'(w_req_valid), 64'd0);
    @(posedge clk);
    #1;
    w_redirect_en = 1'b0;
    @(negedge clk);
    checkOutput("t5_top_valid", 64'(w_req_valid), 64'd1);
    checkOutput("t5_top_addr", 64'(w_req_addr), 64'hFFFF_FFFC);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("t5_wrap_valid", 64'(w_req_valid), 64'd1);
    checkOutput("t5_wrap_addr", 64'(w_req_addr), 64'h0);
    checkOutput("t5_no_fault", 64'(w_fault_valid), 64'd0);
    @(posedge clk);
    #1;
    w_fetch_en = 1'b0;

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
